// File: rtl/pcm_rom_arbiter_pkg.sv
// rtl/pcm_rom_arbiter_pkg.sv - shared types and constants for the PCM ROM line-buffer arbiter
package pcm_rom_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  localparam int LINE_W = 64;
  localparam int OFF_W  = 3;

  function automatic logic [7:0] byte_sel(input logic [LINE_W-1:0] line,
                                          input logic [OFF_W-1:0]  off);
    return line[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/pcm_line_buf.sv
// rtl/pcm_line_buf.sv - one-line read buffer per requester: hit compare, miss latch, fill and byte return
module pcm_line_buf
  import pcm_rom_arbiter_pkg::*;
#(
  parameter int AW = 18
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                inv,
  input  logic                rd,
  input  logic [AW-1:0]       addr,
  input  logic                fill_valid,
  input  logic [AW-OFF_W-1:0] fill_tag,
  input  logic [LINE_W-1:0]   fill_data,
  output logic                pending,
  output logic [AW-OFF_W-1:0] pend_tag,
  output logic [7:0]          data,
  output logic                rdy
);

  logic                valid;
  logic [AW-OFF_W-1:0] tag;
  logic [LINE_W-1:0]   line;
  logic [OFF_W-1:0]    pend_off;
  logic                accept;
  logic                hit;
  logic                fill;

  assign accept = rd & ~inv & ~pending;
  assign hit    = valid & (tag == addr[AW-1:OFF_W]);
  // Any pending request for the fill line is satisfied, granted or not.
  assign fill   = fill_valid & pending & (pend_tag == fill_tag);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      valid    <= 1'b0;
      tag      <= '0;
      line     <= '0;
      pending  <= 1'b0;
      pend_tag <= '0;
      pend_off <= '0;
      data     <= '0;
      rdy      <= 1'b0;
    end else begin
      rdy <= 1'b0;
      if (inv) begin
        valid   <= 1'b0;
        pending <= 1'b0;
      end else if (fill) begin
        line    <= fill_data;
        tag     <= fill_tag;
        valid   <= 1'b1;
        pending <= 1'b0;
        rdy     <= 1'b1;
        data    <= byte_sel(fill_data, pend_off);
      end else if (accept) begin
        if (hit) begin
          rdy  <= 1'b1;
          data <= byte_sel(line, addr[OFF_W-1:0]);
        end else begin
          pending  <= 1'b1;
          pend_tag <= addr[AW-1:OFF_W];
          pend_off <= addr[OFF_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/pcm_rom_arbiter.sv
// rtl/pcm_rom_arbiter.sv - two-requester ROM read arbiter with per-requester line buffers over a DDR channel
module pcm_rom_arbiter
  import pcm_rom_arbiter_pkg::*;
#(
  parameter int AW = 18
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              inv,
  input  logic [1:0]        rq_read,
  input  logic [AW-1:0]     rq_addr0,
  input  logic [AW-1:0]     rq_addr1,
  output logic [7:0]        rq_data0,
  output logic [7:0]        rq_data1,
  output logic [1:0]        rq_rdy,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_req,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_dout
);

  state_t              state;
  state_t              next;
  logic                last;
  logic                abandon;
  logic                pick;
  logic                fill_valid;
  logic [1:0]          pend;
  logic [AW-OFF_W-1:0] pend_tag0;
  logic [AW-OFF_W-1:0] pend_tag1;

  pcm_line_buf #(.AW(AW)) u_buf0 (
    .clk_sys(clk_sys), .reset_n(reset_n), .inv(inv),
    .rd(rq_read[0]), .addr(rq_addr0),
    .fill_valid(fill_valid), .fill_tag(mem_addr[AW-1:OFF_W]), .fill_data(mem_dout),
    .pending(pend[0]), .pend_tag(pend_tag0), .data(rq_data0), .rdy(rq_rdy[0])
  );

  pcm_line_buf #(.AW(AW)) u_buf1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .inv(inv),
    .rd(rq_read[1]), .addr(rq_addr1),
    .fill_valid(fill_valid), .fill_tag(mem_addr[AW-1:OFF_W]), .fill_data(mem_dout),
    .pending(pend[1]), .pend_tag(pend_tag1), .data(rq_data1), .rdy(rq_rdy[1])
  );

  assign mem_req    = (state == ST_ISSUE);
  assign fill_valid = (state == ST_WAIT) & mem_ready & ~abandon & ~inv;

  always_comb begin
    next = state;
    pick = (pend == 2'b11) ? ~last : pend[1];
    case (state)
      ST_IDLE:  if ((|pend) && !inv) next = ST_ISSUE;
      ST_ISSUE: next = ST_WAIT;
      ST_WAIT:  if (mem_ready) next = ST_IDLE;
      default:  next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      last     <= 1'b1;
      abandon  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state <= next;
      if (state == ST_IDLE && next == ST_ISSUE) begin
        mem_addr <= {(pick ? pend_tag1 : pend_tag0), {OFF_W{1'b0}}};
        // The pointer only moves on contested grants.
        if (pend == 2'b11) last <= pick;
      end
      // An invalidate after the request is issued poisons the returning line.
      if (state == ST_IDLE) abandon <= 1'b0;
      else if (inv)         abandon <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcm_rom_arbiter.sv
// tb/tb_pcm_rom_arbiter.sv - scoreboard bench for pcm_rom_arbiter
module tb_pcm_rom_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        inv = 1'b0;
  logic [1:0]  rq_read = 2'b00;
  logic [17:0] rq_addr0 = '0;
  logic [17:0] rq_addr1 = '0;
  logic [7:0]  rq_data0;
  logic [7:0]  rq_data1;
  logic [1:0]  rq_rdy;
  logic [17:0] mem_addr;
  logic        mem_req;
  logic        mem_ready = 1'b0;
  logic [63:0] mem_dout = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  exp_q0[$];
  logic [7:0]  exp_q1[$];
  logic [17:0] exp_mem_q[$];

  pcm_rom_arbiter #(.AW(18)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .inv(inv),
    .rq_read(rq_read), .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
    .rq_data0(rq_data0), .rq_data1(rq_data1), .rq_rdy(rq_rdy),
    .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ready(mem_ready), .mem_dout(mem_dout)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [63:0] line_data(input logic [17:0] a);
    logic [63:0] d;
    if (a == 18'h00100) d = 64'h8877665544332211;
    else for (int n = 0; n < 8; n++) d[n*8 +: 8] = a[10:3] ^ 8'(n * 17 + 1);
    return d;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [17:0] a);
    logic [63:0] d;
    d = line_data({a[17:3], 3'b000});
    return d[a[2:0]*8 +: 8];
  endfunction

  // Scoreboard monitor: every rdy pulse and every mem_req cycle pops one expectation.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (rq_rdy[0]) begin
        vectors++;
        if (exp_q0.size() == 0) begin
          miscompares++;
          $display("FAIL rdy0_unexpected: got pulse data %h, want no pulse", rq_data0);
        end else begin
          logic [7:0] e0;
          e0 = exp_q0.pop_front();
          if (rq_data0 !== e0) begin
            miscompares++;
            $display("FAIL rdy0_data: got %h, want %h", rq_data0, e0);
          end
        end
      end
      if (rq_rdy[1]) begin
        vectors++;
        if (exp_q1.size() == 0) begin
          miscompares++;
          $display("FAIL rdy1_unexpected: got pulse data %h, want no pulse", rq_data1);
        end else begin
          logic [7:0] e1;
          e1 = exp_q1.pop_front();
          if (rq_data1 !== e1) begin
            miscompares++;
            $display("FAIL rdy1_data: got %h, want %h", rq_data1, e1);
          end
        end
      end
      if (mem_req) begin
        vectors++;
        if (exp_mem_q.size() == 0) begin
          miscompares++;
          $display("FAIL mem_req_unexpected: got addr %h, want no request", mem_addr);
        end else begin
          logic [17:0] em;
          em = exp_mem_q.pop_front();
          if (mem_addr !== em) begin
            miscompares++;
            $display("FAIL mem_addr: got %h, want %h", mem_addr, em);
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    inv = 1'b0; rq_read = 2'b00; mem_ready = 1'b0;
    exp_q0.delete(); exp_q1.delete(); exp_mem_q.delete();
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
  endtask

  task automatic read(input logic [1:0] m, input logic [17:0] a0, input logic [17:0] a1);
    @(posedge clk_sys);
    #1 rq_read = m; rq_addr0 = a0; rq_addr1 = a1;
    @(posedge clk_sys);
    #1 rq_read = 2'b00;
  endtask

  task automatic wait_req();
    int n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!mem_req && n < 60);
    if (!mem_req) begin
      vectors++; miscompares++;
      $display("FAIL wait_mem_req: got no mem_req in 60 cycles, want one");
    end
  endtask

  task automatic give_ready();
    @(posedge clk_sys);
    #1 mem_ready = 1'b1; mem_dout = line_data(mem_addr);
    @(posedge clk_sys);
    #1 mem_ready = 1'b0;
  endtask

  task automatic serve(input int lat);
    wait_req();
    repeat (lat) @(posedge clk_sys);
    give_ready();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q0.size() + exp_q1.size() + exp_mem_q.size()) != 0 && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    repeat (4) @(negedge clk_sys);
    vectors++;
    if ((exp_q0.size() + exp_q1.size() + exp_mem_q.size()) != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d/%0d/%0d outstanding, want 0/0/0",
               name, exp_q0.size(), exp_q1.size(), exp_mem_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({rq_rdy, mem_req, mem_addr, rq_data0, rq_data1} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy %b req %b addr %h d0 %h d1 %h, want all 0",
               rq_rdy, mem_req, mem_addr, rq_data0, rq_data1);
    end
    do_reset();
  endtask

  task automatic test_miss_hit();
    do_reset();
    exp_mem_q.push_back(18'h00100);
    exp_q0.push_back(8'h66);
    read(2'b01, 18'h00105, 18'h0);
    serve(2);
    drain("miss");
    exp_q0.push_back(8'h33);
    read(2'b01, 18'h00102, 18'h0);
    @(negedge clk_sys);
    vectors++;
    if (rq_rdy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL hit_latency: got rq_rdy %b, want x1", rq_rdy);
    end
    drain("hit");
  endtask

  task automatic test_round_robin();
    do_reset();
    exp_mem_q.push_back(18'h00200);
    exp_mem_q.push_back(18'h00300);
    exp_q0.push_back(exp_byte(18'h00200));
    exp_q1.push_back(exp_byte(18'h00300));
    read(2'b11, 18'h00200, 18'h00300);
    serve(1);
    serve(3);
    drain("rr_first");
    exp_mem_q.push_back(18'h00600);
    exp_mem_q.push_back(18'h00500);
    exp_q1.push_back(exp_byte(18'h00604));
    exp_q0.push_back(exp_byte(18'h00507));
    read(2'b11, 18'h00507, 18'h00604);
    serve(0);
    serve(2);
    drain("rr_second");
  endtask

  task automatic test_merge();
    do_reset();
    exp_mem_q.push_back(18'h00408);
    exp_q0.push_back(exp_byte(18'h00408));
    exp_q1.push_back(exp_byte(18'h0040F));
    read(2'b11, 18'h00408, 18'h0040F);
    serve(1);
    @(negedge clk_sys);
    vectors++;
    if (rq_rdy !== 2'b11) begin
      miscompares++;
      $display("FAIL merge_rdy: got %b, want 11", rq_rdy);
    end
    drain("merge");
  endtask

  task automatic test_inv_wait();
    do_reset();
    exp_mem_q.push_back(18'h00700);
    read(2'b01, 18'h00703, 18'h0);
    wait_req();
    @(posedge clk_sys);
    #1 inv = 1'b1;
    @(posedge clk_sys);
    #1 inv = 1'b0;
    give_ready();
    repeat (5) @(posedge clk_sys);
    exp_mem_q.push_back(18'h00700);
    exp_q0.push_back(exp_byte(18'h00703));
    read(2'b01, 18'h00703, 18'h0);
    serve(1);
    drain("inv_wait");
  endtask

  task automatic test_reset_wait();
    do_reset();
    exp_mem_q.push_back(18'h00900);
    exp_q1.push_back(exp_byte(18'h00901));
    read(2'b10, 18'h0, 18'h00901);
    serve(0);
    drain("warm");
    exp_mem_q.push_back(18'h00800);
    read(2'b01, 18'h00800, 18'h0);
    wait_req();
    repeat (2) @(posedge clk_sys);
    #3 reset_n = 1'b0;
    #1;
    vectors++;
    if ({rq_rdy, mem_req, mem_addr, rq_data0, rq_data1} !== '0) begin
      miscompares++;
      $display("FAIL reset_wait_outputs: got rdy %b req %b addr %h d0 %h d1 %h, want all 0",
               rq_rdy, mem_req, mem_addr, rq_data0, rq_data1);
    end
    @(posedge clk_sys);
    #1 reset_n = 1'b1;
    mem_ready = 1'b1; mem_dout = line_data(18'h00800);
    @(posedge clk_sys);
    #1 mem_ready = 1'b0;
    repeat (4) @(posedge clk_sys);
    exp_mem_q.push_back(18'h00900);
    exp_q1.push_back(exp_byte(18'h00906));
    read(2'b10, 18'h0, 18'h00906);
    serve(1);
    drain("reset_wait");
  endtask

  task automatic test_hit_during_wait();
    do_reset();
    exp_mem_q.push_back(18'h00A00);
    exp_q1.push_back(exp_byte(18'h00A05));
    read(2'b10, 18'h0, 18'h00A05);
    serve(1);
    drain("hw_warm");
    exp_mem_q.push_back(18'h00B00);
    exp_q0.push_back(exp_byte(18'h00B02));
    read(2'b01, 18'h00B02, 18'h0);
    wait_req();
    exp_q1.push_back(exp_byte(18'h00A03));
    read(2'b10, 18'h0, 18'h00A03);
    @(negedge clk_sys);
    vectors++;
    if (rq_rdy !== 2'b10) begin
      miscompares++;
      $display("FAIL hit_during_wait: got rq_rdy %b, want 10", rq_rdy);
    end
    repeat (17) @(posedge clk_sys);
    give_ready();
    drain("hit_during_wait");
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_round_robin();
    test_merge();
    test_inv_wait();
    test_reset_wait();
    test_hit_during_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
